// File: rtl/pixel_frame_tx.sv
// Frame buffer plus valid/ready streamer for the CNN pixel loader image-load link.
// Optional trailing checksum beat enabled by defining PIXEL_FRAME_TX_CHECKSUM_EN.
module pixel_frame_tx #(
    parameter int unsigned NUM_PIXELS = 64,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ADDR_W     = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    output logic              busy,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_last,
    output logic              done
);

    typedef enum logic [1:0] {StIdle, StSend, StDone, StCsum} state_e;

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_PIXELS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [DATA_W-1:0] frame_q [NUM_PIXELS];
    logic              pix_last;
    logic              xfer;

    assign pix_last = (index_q == LastIdx);
    assign xfer     = tx_valid && tx_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
        end
    end

    // The buffer is only writable while idle so a frame in flight is never torn.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PIXELS; i++) begin
                frame_q[i] <= '0;
            end
        end else if (wr_en && state_q == StIdle) begin
            frame_q[wr_addr] <= wr_data;
        end
    end

`ifdef PIXEL_FRAME_TX_CHECKSUM_EN
    logic [7:0] sum_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= '0;
        end else if (state_q == StIdle && start) begin
            sum_q <= '0;
        end else if (state_q == StSend && tx_ready) begin
            sum_q <= sum_q + 8'(tx_data);
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSend;
                    index_d = '0;
                end
            end
            StSend: begin
                if (xfer) begin
                    if (pix_last) begin
`ifdef PIXEL_FRAME_TX_CHECKSUM_EN
                        state_d = StCsum;
`else
                        state_d = StDone;
`endif
                        index_d = '0;
                    end else begin
                        index_d = index_q + ADDR_W'(1);
                    end
                end
            end
            StCsum: begin
                if (xfer) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
                index_d = '0;
            end
            default: begin
                state_d = StIdle;
                index_d = '0;
            end
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        done     = 1'b0;
        tx_data  = '0;
        unique case (state_q)
            StIdle: begin
            end
            StSend: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = frame_q[index_q];
`ifndef PIXEL_FRAME_TX_CHECKSUM_EN
                tx_last  = pix_last;
`endif
            end
            StCsum: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_last  = 1'b1;
`ifdef PIXEL_FRAME_TX_CHECKSUM_EN
                tx_data  = DATA_W'(sum_q);
`endif
            end
            StDone: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_pixel_frame_tx.sv
// Randomized self-checking bench for pixel_frame_tx against a frame-level reference model.
module tb_pixel_frame_tx;

    localparam int N = 64;
`ifdef PIXEL_FRAME_TX_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif
    localparam int BEATS = N + (CSUM ? 1 : 0);

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [5:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       start = 1'b0;
    logic       busy;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       tx_last;
    logic       done;

    int errors = 0;
    int checks = 0;

    // Reference model: frame contents and the beats a frame must produce.
    logic [7:0] model_buf [N];
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    int done_cnt, done_cyc, last_cnt, last_pos, stall_err, busy_err;
    bit timeout;

    pixel_frame_tx dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .start    (start),
        .busy     (busy),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_last  (tx_last),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
        $fatal(1);
    end

    function automatic void build_exp();
        int s = 0;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            exp_q.push_back(model_buf[i]);
            s += int'(model_buf[i]);
        end
        if (CSUM) exp_q.push_back(8'(s % 256));
    endfunction

    task automatic write_pix(input int addr, input int data);
        wr_en   = 1'b1;
        wr_addr = 6'(addr);
        wr_data = 8'(data);
        model_buf[addr] = 8'(data);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // mode 0: ready always high, 1: pattern 1,0,0 repeating, 2: random ready.
    task automatic run_frame(input int mode, input bit inject);
        int c = 1;
        int post = -1;
        bit hold = 0;
        logic [7:0] hold_data = '0;
        got_q.delete();
        done_cnt = 0; done_cyc = -1; last_cnt = 0; last_pos = -1;
        stall_err = 0; busy_err = 0; timeout = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        while (c < 2000 && post < 3) begin
            if (mode == 0) tx_ready = 1'b1;
            else if (mode == 1) tx_ready = ((c - 1) % 3 == 0);
            else tx_ready = 1'($urandom_range(0, 1));
            if (inject && c == 10) begin
                wr_en = 1'b1; wr_addr = 6'd5; wr_data = 8'hAA; start = 1'b1;
            end else if (inject && c == 11) begin
                wr_en = 1'b0; start = 1'b0;
            end
            if (hold && (tx_valid !== 1'b1 || tx_data !== hold_data)) stall_err++;
            if (done_cnt == 0 && busy !== 1'b1) busy_err++;
            if (tx_valid === 1'b1) begin
                if (tx_ready) begin
                    got_q.push_back(tx_data);
                    if (tx_last === 1'b1) begin
                        last_cnt++;
                        last_pos = got_q.size() - 1;
                    end
                    hold = 0;
                end else begin
                    hold = 1;
                    hold_data = tx_data;
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cnt > 0) post++;
            @(negedge clk);
            c++;
        end
        tx_ready = 1'b0;
        if (post < 3) timeout = 1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", tx_valid); end
        checks++; if (tx_last !== 1'b0) begin errors++; $display("FAIL reset_last got=%b want=0", tx_last); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h want=00", tx_data); end
        reset = 1'b0;
        for (int i = 0; i < N; i++) model_buf[i] = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_zero_frame();
        build_exp();
        run_frame(0, 0);
        checks++; if (timeout) begin errors++; $display("FAIL zero_timeout got=timeout want=done"); end
        checks++; if (got_q.size() != BEATS) begin errors++; $display("FAIL zero_len got=%0d want=%0d", got_q.size(), BEATS); end
        for (int i = 0; i < BEATS && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL zero_beat%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (last_cnt != 1 || last_pos != BEATS - 1) begin errors++; $display("FAIL zero_last got=cnt%0d/pos%0d want=cnt1/pos%0d", last_cnt, last_pos, BEATS - 1); end
        checks++; if (done_cyc != BEATS + 1) begin errors++; $display("FAIL zero_done_cycle got=%0d want=%0d", done_cyc, BEATS + 1); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done_count got=%0d want=1", done_cnt); end
    endtask

    task automatic test_ramp();
        for (int i = 0; i < N; i++) write_pix(i, i);
        build_exp();
        run_frame(0, 0);
        checks++; if (got_q.size() != BEATS) begin errors++; $display("FAIL ramp_len got=%0d want=%0d", got_q.size(), BEATS); end
        for (int i = 0; i < BEATS && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ramp_beat%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (busy_err != 0) begin errors++; $display("FAIL ramp_busy got=%0d lapses want=0", busy_err); end
        checks++; if (last_pos != BEATS - 1) begin errors++; $display("FAIL ramp_last got=%0d want=%0d", last_pos, BEATS - 1); end
        checks++; if (done_cyc != BEATS + 1) begin errors++; $display("FAIL ramp_done_cycle got=%0d want=%0d", done_cyc, BEATS + 1); end
    endtask

    task automatic test_stall();
        build_exp();
        run_frame(1, 0);
        checks++; if (got_q.size() != BEATS) begin errors++; $display("FAIL stall_len got=%0d want=%0d", got_q.size(), BEATS); end
        for (int i = 0; i < BEATS && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_beat%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (stall_err != 0) begin errors++; $display("FAIL stall_stable got=%0d unstable cycles want=0", stall_err); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL stall_done_count got=%0d want=1", done_cnt); end
    endtask

    task automatic test_ignore_busy();
        build_exp();
        run_frame(0, 1);
        checks++; if (got_q.size() != BEATS) begin errors++; $display("FAIL ignore_len got=%0d want=%0d", got_q.size(), BEATS); end
        if (got_q.size() > 5) begin
            checks++; if (got_q[5] !== 8'h05) begin errors++; $display("FAIL ignore_beat5 got=%h want=05", got_q[5]); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL ignore_done_count got=%0d want=1", done_cnt); end
        run_frame(0, 0);
        if (got_q.size() > 5) begin
            checks++; if (got_q[5] !== model_buf[5]) begin errors++; $display("FAIL ignore_buf5 got=%h want=%h", got_q[5], model_buf[5]); end
        end
    endtask

    task automatic test_same_cycle();
        wr_en = 1'b1; wr_addr = 6'd0; wr_data = 8'h7F;
        model_buf[0] = 8'h7F;
        build_exp();
        run_frame(0, 0);
        checks++; if (got_q.size() == 0 || got_q[0] !== 8'h7F) begin errors++; $display("FAIL same_cycle_first got=%h want=7f", (got_q.size() > 0) ? got_q[0] : 8'hxx); end
        checks++; if (got_q.size() != BEATS || got_q[BEATS-1] !== exp_q[BEATS-1]) begin errors++; $display("FAIL same_cycle_tail got=len%0d want=len%0d tail=%h", got_q.size(), BEATS, exp_q[BEATS-1]); end
    endtask

    task automatic test_abort();
        int beats = 0;
        int c = 0;
        int dn = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tx_ready = 1'b1;
        while (beats < 30 && c < 200) begin
            if (tx_valid === 1'b1) beats++;
            @(negedge clk);
            c++;
        end
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL abort_mid_valid got=%b want=1", tx_valid); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got=%b want=0", tx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b want=0", busy); end
        reset = 1'b0;
        for (int i = 0; i < N; i++) model_buf[i] = 8'h00;
        for (int i = 0; i < 80; i++) begin
            if (done === 1'b1) dn++;
            @(negedge clk);
        end
        checks++; if (dn != 0) begin errors++; $display("FAIL abort_done got=%0d pulses want=0", dn); end
        build_exp();
        run_frame(0, 0);
        checks++; if (got_q.size() != BEATS) begin errors++; $display("FAIL abort_len got=%0d want=%0d", got_q.size(), BEATS); end
        for (int i = 0; i < BEATS && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL abort_beat%0d got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 40; k++) write_pix($urandom_range(0, N - 1), $urandom_range(0, 255));
            build_exp();
            run_frame(2, 0);
            checks++; if (got_q.size() != BEATS) begin errors++; $display("FAIL rand%0d_len got=%0d want=%0d", f, got_q.size(), BEATS); end
            for (int i = 0; i < BEATS && i < got_q.size(); i++) begin
                checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_beat%0d got=%h want=%h", f, i, got_q[i], exp_q[i]); end
            end
            checks++; if (stall_err != 0 || last_pos != BEATS - 1) begin errors++; $display("FAIL rand%0d_proto got=stall%0d/last%0d want=stall0/last%0d", f, stall_err, last_pos, BEATS - 1); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_zero_frame();
        test_ramp();
        test_stall();
        test_ignore_busy();
        test_same_cycle();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
